// File: rtl/enc8x3_seq_if.sv
// Handshake bundle between the register-select producer/consumer and the
// sequential 8-to-3 encoder.
interface enc8x3_seq_if;
  logic [7:0] mask_in;
  logic       load;
  logic       busy;
  logic [2:0] idx;
  logic       idx_valid;
  logic       idx_ready;
  logic       last;
  logic       done;
  logic [3:0] count;

  // Producer side: supplies the mask and accepts indices.
  modport master (
    output mask_in, load, idx_ready,
    input  busy, idx, idx_valid, last, done, count
  );

  // Encoder side.
  modport slave (
    input  mask_in, load, idx_ready,
    output busy, idx, idx_valid, last, done, count
  );
endinterface

// File: rtl/enc8x3_seq.sv
// Sequential 8-to-3 encoder: latches a multi-hot register-select mask and
// emits the index of each set bit, one per handshake, in priority order.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | no pending bits; waiting for load
//   ST_EMIT | pend non-zero; idx/last presented with idx_valid=1
module enc8x3_seq #(
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  enc8x3_seq_if.slave  bus
);

  typedef enum logic {ST_IDLE, ST_EMIT} state_t;

  state_t     state_q, state_d;
  logic [7:0] pend_q,  pend_d;
  logic [3:0] count_q, count_d;
  logic       done_q,  done_d;

  logic [2:0] idx_c;
  logic       last_c;
  logic [3:0] pop_c;
  logic       fire_c;

  // Priority-encode the pending set; pend is zero in IDLE so idx falls to 0.
  always_comb begin
    idx_c = 3'd0;
    if (LSB_FIRST != 0) begin
      for (int i = 7; i >= 0; i--) begin
        if (pend_q[i]) idx_c = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (pend_q[i]) idx_c = 3'(i);
      end
    end
    last_c = (pend_q != 8'd0) && ((pend_q & (pend_q - 8'd1)) == 8'd0);
  end

  // Popcount of the incoming mask, captured only when a load is accepted.
  always_comb begin
    pop_c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      pop_c = pop_c + 4'(bus.mask_in[i]);
    end
  end

  // Next-state logic for the pending mask, count and done pulse.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    count_d = count_q;
    done_d  = 1'b0;
    fire_c  = (state_q == ST_EMIT) && bus.idx_ready;
    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          count_d = pop_c;
          if (bus.mask_in != 8'd0) begin
            pend_d  = bus.mask_in;
            state_d = ST_EMIT;
          end else begin
            // Empty mask: nothing to emit, report completion immediately.
            done_d = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (fire_c) begin
          pend_d = pend_q & ~(8'd1 << idx_c);
          if (last_c) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; synchronous reset drops any in-flight mask without done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= 8'd0;
      count_q <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = (state_q == ST_EMIT);
  assign bus.idx_valid = (state_q == ST_EMIT);
  assign bus.idx       = idx_c;
  assign bus.last      = last_c && (state_q == ST_EMIT);
  assign bus.done      = done_q;
  assign bus.count     = count_q;

endmodule
